// File: rtl/gs_cfg_pager.sv
`default_nettype none
// ============================================================================
//  Module   : gs_cfg_pager
//  Purpose  : NewGS glue between the Z80 bus, ROM/RAM and the ACEX1K FPGA.
//             - Memory paging: ROM page 0 at 0000-3FFF, RAM page 0 at
//               4000-7FFF, and a paged 32K ROM/RAM window at 8000-FFFF.
//             - FPGA configuration sequencer with timeouts and error status.
//             - Hands the memory/CS pins over to the FPGA once configured,
//               and issues a counted warm-reset pulse at each handover.
//  Ports    : clkin, coldres_n        clock / synchronous active-low reset
//             a15,a14,a7,a6           Z80 address bits
//             iorq_n,mreq_n,rd_n,wr_n Z80 strobes
//             din / dout, dout_oe     Z80 data in / read data + drive enable
//             mema, romcs_n, ramcs0_n, memoe_n, memwe_n, fpga_cs
//                                     memory and FPGA select outputs
//             bus_en                  1 = this block owns the memory pins
//             config_n, status_n, conf_done, init_done  FPGA config pins
//             warmres_n               warm reset output, active low
//  Revision : 1.0  initial release
// ============================================================================
module gs_cfg_pager #(
    parameter int PAGE_BITS   = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CFG_LOW_CYC = 8,
    parameter int TMO_W       = 16,
    parameter int RST_W       = 4
) (
    input  logic                 clkin,
    input  logic                 coldres_n,
    input  logic                 a15,
    input  logic                 a14,
    input  logic                 a7,
    input  logic                 a6,
    input  logic                 iorq_n,
    input  logic                 mreq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic [7:0]           din,
    output logic [7:0]           dout,
    output logic                 dout_oe,
    output logic [PAGE_BITS:0]   mema,
    output logic                 romcs_n,
    output logic                 ramcs0_n,
    output logic                 memoe_n,
    output logic                 memwe_n,
    output logic                 fpga_cs,
    output logic                 bus_en,
    output logic                 config_n,
    input  logic                 status_n,
    input  logic                 conf_done,
    input  logic                 init_done,
    output logic                 warmres_n
);

    localparam int CNT_W = $clog2(CFG_LOW_CYC) + 1;

    localparam logic [2:0] c_st_cfg_low   = 3'd0;
    localparam logic [2:0] c_st_wait_st   = 3'd1;
    localparam logic [2:0] c_st_config    = 3'd2;
    localparam logic [2:0] c_st_wait_init = 3'd3;
    localparam logic [2:0] c_st_done      = 3'd4;
    localparam logic [2:0] c_st_error     = 3'd5;

    // Synchroniser bundle: {init_done, conf_done, status_n, wr_n, iorq_n}.
    // Reset values match the idle level of each pin.
    localparam logic [4:0] c_sync_rst = 5'b00111;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [4:0] r_sync_q [SYNC_STAGES];
    logic [4:0] w_sync_d [SYNC_STAGES];

    always_comb begin
        w_sync_d[0] = {init_done, conf_done, status_n, wr_n, iorq_n};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            w_sync_d[i] = r_sync_q[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clkin) begin
                if (!coldres_n) begin
                    r_sync_q[gi] <= c_sync_rst;
                end else begin
                    r_sync_q[gi] <= w_sync_d[gi];
                end
            end
        end
    endgenerate

    logic w_iorq_s, w_wr_s, w_status_s, w_conf_s, w_init_s;
    assign w_iorq_s   = r_sync_q[SYNC_STAGES-1][0];
    assign w_wr_s     = r_sync_q[SYNC_STAGES-1][1];
    assign w_status_s = r_sync_q[SYNC_STAGES-1][2];
    assign w_conf_s   = r_sync_q[SYNC_STAGES-1][3];
    assign w_init_s   = r_sync_q[SYNC_STAGES-1][4];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [PAGE_BITS-1:0] r_page_q,       w_page_d;
    logic                 r_ram_sel_q,    w_ram_sel_d;
    logic                 r_was_cold_n_q, w_was_cold_n_d;
    logic                 r_cfg_req_q,    w_cfg_req_d;
    logic [2:0]           r_state_q,      w_state_d;
    logic [CNT_W-1:0]     r_cnt_q,        w_cnt_d;
    logic [TMO_W-1:0]     r_tmo_q,        w_tmo_d;
    logic                 r_err_q,        w_err_d;
    logic                 r_bus_en_q,     w_bus_en_d;
    logic [RST_W-1:0]     r_rstcnt_q,     w_rstcnt_d;
    logic                 r_warmres_n_q,  w_warmres_n_d;
    logic [7:0]           r_dout_q,       w_dout_d;
    logic [7:0]           r_din_q,        w_din_d;
    logic [1:0]           r_a76_q,        w_a76_d;
    logic                 r_wstb_prev_q,  w_wstb_prev_d;

    // ------------------------------------------------------------------
    // Port write strobe: data and port bits are captured while the
    // synchronised strobe is low, and committed once on its rising edge.
    // ------------------------------------------------------------------
    logic w_wstb_s, w_wr_rise, w_wr01, w_wr10, w_force_cfg;

    assign w_wstb_s    = w_iorq_s | w_wr_s;
    assign w_wr_rise   = w_wstb_s & ~r_wstb_prev_q;
    assign w_wr01      = w_wr_rise & (r_a76_q == 2'b01);
    assign w_wr10      = w_wr_rise & (r_a76_q == 2'b10);
    assign w_force_cfg = w_wr10 & ~r_din_q[0];

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    logic w_tmo_full, w_cnt_ok;

    assign w_tmo_full = (r_tmo_q == {TMO_W{1'b1}});
    assign w_cnt_ok   = (int'(r_cnt_q) >= CFG_LOW_CYC - 1);

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_st_cfg_low: begin
                if (w_cnt_ok && r_cfg_req_q) w_state_d = c_st_wait_st;
            end
            // Progress is tested before the timeout so it wins a tie.
            c_st_wait_st: begin
                if (w_status_s)      w_state_d = c_st_config;
                else if (w_tmo_full) w_state_d = c_st_error;
            end
            c_st_config: begin
                if (!w_status_s)     w_state_d = c_st_error;
                else if (w_conf_s)   w_state_d = c_st_wait_init;
                else if (w_tmo_full) w_state_d = c_st_error;
            end
            c_st_wait_init: begin
                if (w_init_s)        w_state_d = c_st_done;
                else if (w_tmo_full) w_state_d = c_st_error;
            end
            c_st_done, c_st_error: begin
                w_state_d = r_state_q;
            end
            default: begin
                w_state_d = c_st_cfg_low;
            end
        endcase
        // A control write with d0=0 restarts configuration from anywhere.
        if (w_force_cfg) w_state_d = c_st_cfg_low;
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic w_config_n;

    always_comb begin
        w_config_n = (r_state_q != c_st_cfg_low);
        // Registered so the pins are released in the same cycle DONE begins.
        w_bus_en_d = (w_state_d != c_st_done);
    end

    // ------------------------------------------------------------------
    // Datapath / counters next-state
    // ------------------------------------------------------------------
    logic w_enter_cfg, w_enter_done, w_timed_state;

    assign w_enter_cfg   = w_force_cfg ||
                           ((w_state_d == c_st_cfg_low) && (r_state_q != c_st_cfg_low));
    assign w_enter_done  = (w_state_d == c_st_done) && (r_state_q != c_st_done);
    assign w_timed_state = (r_state_q == c_st_wait_st) || (r_state_q == c_st_config) ||
                           (r_state_q == c_st_wait_init);

    always_comb begin
        w_page_d       = r_page_q;
        w_ram_sel_d    = r_ram_sel_q;
        w_was_cold_n_d = r_was_cold_n_q;
        w_cfg_req_d    = r_cfg_req_q;
        w_din_d        = r_din_q;
        w_a76_d        = r_a76_q;
        w_wstb_prev_d  = w_wstb_s;

        if (!w_wstb_s) begin
            w_din_d = din;
            w_a76_d = {a7, a6};
        end

        if (w_wr01) begin
            w_ram_sel_d = r_din_q[7];
            w_page_d    = r_din_q[PAGE_BITS-1:0];
        end
        if (w_wr10) begin
            w_was_cold_n_d = r_was_cold_n_q | r_din_q[7];
            w_cfg_req_d    = r_din_q[0];
        end

        // config_n low time is measured from each entry into CFG_LOW.
        if (w_enter_cfg) begin
            w_cnt_d = '0;
        end else if ((r_state_q == c_st_cfg_low) && (r_cnt_q != {CNT_W{1'b1}})) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end else begin
            w_cnt_d = r_cnt_q;
        end

        if ((w_state_d != r_state_q) || w_force_cfg || !w_timed_state) begin
            w_tmo_d = '0;
        end else begin
            w_tmo_d = r_tmo_q + 1'b1;
        end

        if (w_enter_cfg) begin
            w_err_d = 1'b0;
        end else if (w_state_d == c_st_error) begin
            w_err_d = 1'b1;
        end else begin
            w_err_d = r_err_q;
        end

        // Warm reset: reload on DONE entry, otherwise count down to zero.
        // The output is forced low in the entry cycle so the pulse spans
        // exactly 2**RST_W cycles, the same as after a cold reset.
        if (w_enter_done) begin
            w_rstcnt_d = {RST_W{1'b1}};
        end else if (r_rstcnt_q != '0) begin
            w_rstcnt_d = r_rstcnt_q - 1'b1;
        end else begin
            w_rstcnt_d = r_rstcnt_q;
        end
        w_warmres_n_d = (r_rstcnt_q == '0) && !w_enter_done;

        case ({a7, a6})
            2'b01:   w_dout_d = {r_was_cold_n_q, 7'b0};
            2'b10:   w_dout_d = {w_status_s, r_err_q, r_state_q, 2'b00, w_conf_s};
            default: w_dout_d = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and remaining flops
    // ------------------------------------------------------------------
    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            r_state_q <= c_st_cfg_low;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_ff @(posedge clkin) begin
        if (!coldres_n) begin
            r_page_q       <= '0;
            r_ram_sel_q    <= 1'b0;
            r_was_cold_n_q <= 1'b0;
            r_cfg_req_q    <= 1'b0;
            r_cnt_q        <= '0;
            r_tmo_q        <= '0;
            r_err_q        <= 1'b0;
            r_bus_en_q     <= 1'b1;
            r_rstcnt_q     <= {RST_W{1'b1}};
            r_warmres_n_q  <= 1'b0;
            r_dout_q       <= 8'h00;
            r_din_q        <= 8'h00;
            r_a76_q        <= 2'b00;
            r_wstb_prev_q  <= 1'b1;
        end else begin
            r_page_q       <= w_page_d;
            r_ram_sel_q    <= w_ram_sel_d;
            r_was_cold_n_q <= w_was_cold_n_d;
            r_cfg_req_q    <= w_cfg_req_d;
            r_cnt_q        <= w_cnt_d;
            r_tmo_q        <= w_tmo_d;
            r_err_q        <= w_err_d;
            r_bus_en_q     <= w_bus_en_d;
            r_rstcnt_q     <= w_rstcnt_d;
            r_warmres_n_q  <= w_warmres_n_d;
            r_dout_q       <= w_dout_d;
            r_din_q        <= w_din_d;
            r_a76_q        <= w_a76_d;
            r_wstb_prev_q  <= w_wstb_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory decode
    // ------------------------------------------------------------------
    logic [PAGE_BITS:0] w_mema;
    logic               w_romcs_n, w_ramcs0_n;

    always_comb begin
        w_mema     = '0;
        w_romcs_n  = 1'b1;
        w_ramcs0_n = 1'b1;
        case ({a15, a14})
            2'b00: begin
                w_romcs_n = 1'b0;
            end
            2'b01: begin
                w_ramcs0_n = 1'b0;
            end
            default: begin
                w_mema     = {r_page_q, a14};
                w_romcs_n  = r_ram_sel_q;
                w_ramcs0_n = ~r_ram_sel_q;
            end
        endcase
    end

    // With the bus handed over, drive the idle levels behind the tri-state.
    assign mema      = r_bus_en_q ? w_mema : '0;
    assign romcs_n   = r_bus_en_q ? w_romcs_n : 1'b1;
    assign ramcs0_n  = r_bus_en_q ? w_ramcs0_n : 1'b1;
    assign memoe_n   = r_bus_en_q ? (mreq_n | rd_n) : 1'b1;
    assign memwe_n   = r_bus_en_q ? (mreq_n | wr_n) : 1'b1;
    assign fpga_cs   = r_bus_en_q & a7 & a6;
    assign bus_en    = r_bus_en_q;
    assign config_n  = w_config_n;
    assign warmres_n = r_warmres_n_q;
    assign dout      = r_dout_q;
    assign dout_oe   = ~iorq_n & ~rd_n & (a7 ^ a6);

    // Read data is refreshed every cycle from the raw address, so rd_n only
    // feeds dout_oe; only some captured data bits are consumed by commits.
    logic w_unused;
    assign w_unused = ^{r_din_q, rd_n};

endmodule
`default_nettype wire

// File: tb/tb_gs_cfg_pager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gs_cfg_pager
//  Purpose  : Self-checking bench for gs_cfg_pager (TMO_W=4 so timeouts are
//             short). Expected read data is queued when stimulus is driven
//             and popped when the DUT presents it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gs_cfg_pager;

    logic       clk = 1'b0;
    logic       coldres_n = 1'b0;
    logic       a15 = 1'b0, a14 = 1'b0, a7 = 1'b0, a6 = 1'b0;
    logic       iorq_n = 1'b1, mreq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       dout_oe;
    logic [3:0] mema;
    logic       romcs_n, ramcs0_n, memoe_n, memwe_n, fpga_cs, bus_en, config_n;
    logic       status_n = 1'b0, conf_done = 1'b0, init_done = 1'b0;
    logic       warmres_n;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    gs_cfg_pager #(
        .PAGE_BITS(3), .SYNC_STAGES(2), .CFG_LOW_CYC(8), .TMO_W(4), .RST_W(4)
    ) dut (
        .clkin(clk), .coldres_n(coldres_n),
        .a15(a15), .a14(a14), .a7(a7), .a6(a6),
        .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .din(din), .dout(dout), .dout_oe(dout_oe),
        .mema(mema), .romcs_n(romcs_n), .ramcs0_n(ramcs0_n),
        .memoe_n(memoe_n), .memwe_n(memwe_n), .fpga_cs(fpga_cs), .bus_en(bus_en),
        .config_n(config_n), .status_n(status_n), .conf_done(conf_done),
        .init_done(init_done), .warmres_n(warmres_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // Z80 OUT cycle; address/data held until the commit has happened.
    task automatic out_port(input logic [1:0] port, input logic [7:0] data);
        a7 = port[1]; a6 = port[0]; din = data; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 iorq_n = 1'b1; wr_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic in_begin(input logic [1:0] port);
        a7 = port[1]; a6 = port[0]; iorq_n = 1'b0; rd_n = 1'b0;
    endtask

    task automatic in_end();
        iorq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        @(posedge clk); #1;
        coldres_n = 1'b0; a15 = 1'b1; a14 = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
        @(posedge clk); #1 coldres_n = 1'b1;
        @(negedge clk);
        n_chk++; if (romcs_n !== 1'b0) $display("FAIL rst_romcs: got %b want 0", romcs_n); else n_pass++;
        n_chk++; if (ramcs0_n !== 1'b1) $display("FAIL rst_ramcs: got %b want 1", ramcs0_n); else n_pass++;
        n_chk++; if (mema !== 4'b0000) $display("FAIL rst_mema: got %b want 0000", mema); else n_pass++;
        n_chk++; if (memoe_n !== 1'b0) $display("FAIL rst_memoe: got %b want 0", memoe_n); else n_pass++;
        n_chk++; if (config_n !== 1'b0) $display("FAIL rst_config_n: got %b want 0", config_n); else n_pass++;
        n_chk++; if (bus_en !== 1'b1) $display("FAIL rst_bus_en: got %b want 1", bus_en); else n_pass++;
        n_chk++; if (dout !== 8'h00) $display("FAIL rst_dout: got %h want 00", dout); else n_pass++;
        n_chk++; if (dout_oe !== 1'b0) $display("FAIL rst_dout_oe: got %b want 0", dout_oe); else n_pass++;
        n = 0;
        while (warmres_n === 1'b0 && n < 40) begin n++; @(negedge clk); end
        n_chk++; if (n != 16) $display("FAIL rst_warm_len: got %0d want 16", n); else n_pass++;
        a14 = 1'b1; #1;
        n_chk++; if (mema !== 4'b0001) $display("FAIL rst_page0: got %b want 0001", mema); else n_pass++;
        a15 = 1'b0; #1;
        n_chk++; if (ramcs0_n !== 1'b0 || romcs_n !== 1'b1)
            $display("FAIL rst_ram0: got ram%b rom%b want ram0 rom1", ramcs0_n, romcs_n); else n_pass++;
        mreq_n = 1'b1; rd_n = 1'b1;
    endtask

    task automatic test_paging();
        out_port(2'b01, 8'h85);
        a15 = 1'b1; a14 = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        n_chk++; if (mema !== 4'b1011) $display("FAIL pg_mema_c000: got %b want 1011", mema); else n_pass++;
        n_chk++; if (ramcs0_n !== 1'b0 || romcs_n !== 1'b1)
            $display("FAIL pg_ramwin: got ram%b rom%b want ram0 rom1", ramcs0_n, romcs_n); else n_pass++;
        a14 = 1'b0; @(negedge clk);
        n_chk++; if (mema !== 4'b1010) $display("FAIL pg_mema_8000: got %b want 1010", mema); else n_pass++;
        rd_n = 1'b1; wr_n = 1'b0; @(negedge clk);
        n_chk++; if (memwe_n !== 1'b0 || memoe_n !== 1'b1)
            $display("FAIL pg_we: got we%b oe%b want we0 oe1", memwe_n, memoe_n); else n_pass++;
        wr_n = 1'b1; mreq_n = 1'b1; a7 = 1'b1; a6 = 1'b1; @(negedge clk);
        n_chk++; if (fpga_cs !== 1'b1) $display("FAIL pg_fpga_cs: got %b want 1", fpga_cs); else n_pass++;
        // was_cold_n still clear after reset
        exp_q.push_back(8'h00);
        in_begin(2'b01);
        repeat (2) @(negedge clk);
        n_chk++; if (dout_oe !== 1'b1) $display("FAIL pg_dout_oe: got %b want 1", dout_oe); else n_pass++;
        e = exp_q.pop_front();
        n_chk++; if (dout !== e) $display("FAIL pg_in01: got %h want %h", dout, e); else n_pass++;
        in_end();
        out_port(2'b01, 8'h02);
        a15 = 1'b1; a14 = 1'b1; @(negedge clk);
        n_chk++; if (mema !== 4'b0101 || romcs_n !== 1'b0)
            $display("FAIL pg_rom_p2: got mema%b rom%b want 0101 rom0", mema, romcs_n); else n_pass++;
    endtask

    task automatic test_config_walk();
        int k;
        status_n = 1'b0; conf_done = 1'b0; init_done = 1'b0;
        a15 = 1'b0; a14 = 1'b0; mreq_n = 1'b0;
        exp_q.push_back(8'd1);
        out_port(2'b10, 8'h81);
        in_begin(2'b10);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        n_chk++; if (dout[5:3] !== e[2:0]) $display("FAIL cw_wait_st: got %0d want %0d", dout[5:3], e[2:0]); else n_pass++;
        n_chk++; if (config_n !== 1'b1) $display("FAIL cw_config_n: got %b want 1", config_n); else n_pass++;
        exp_q.push_back(8'd2);
        status_n = 1'b1;
        k = 0; while (dout[5:3] === 3'd1 && k < 20) begin @(negedge clk); k++; end
        e = exp_q.pop_front();
        n_chk++; if (dout[5:3] !== e[2:0]) $display("FAIL cw_config: got %0d want %0d", dout[5:3], e[2:0]); else n_pass++;
        exp_q.push_back(8'd3);
        conf_done = 1'b1;
        k = 0; while (dout[5:3] === 3'd2 && k < 20) begin @(negedge clk); k++; end
        e = exp_q.pop_front();
        n_chk++; if (dout[5:3] !== e[2:0]) $display("FAIL cw_wait_init: got %0d want %0d", dout[5:3], e[2:0]); else n_pass++;
        n_chk++; if (warmres_n !== 1'b1 || bus_en !== 1'b1)
            $display("FAIL cw_pre_done: got warm%b bus%b want 1 1", warmres_n, bus_en); else n_pass++;
        exp_q.push_back(8'd4);
        init_done = 1'b1;
        k = 0; while (warmres_n === 1'b1 && k < 20) begin @(negedge clk); k++; end
        n_chk++; if (bus_en !== 1'b0) $display("FAIL cw_bus_en: got %b want 0", bus_en); else n_pass++;
        n_chk++; if (romcs_n !== 1'b1 || memoe_n !== 1'b1)
            $display("FAIL cw_gated: got rom%b oe%b want 1 1", romcs_n, memoe_n); else n_pass++;
        k = 0;
        while (warmres_n === 1'b0 && k < 40) begin k++; @(negedge clk); end
        n_chk++; if (k != 16) $display("FAIL cw_warm_len: got %0d want 16", k); else n_pass++;
        e = exp_q.pop_front();
        n_chk++; if (dout[5:3] !== e[2:0]) $display("FAIL cw_done: got %0d want %0d", dout[5:3], e[2:0]); else n_pass++;
        in_end();
        mreq_n = 1'b1;
        exp_q.push_back(8'h80);
        in_begin(2'b01);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        n_chk++; if (dout !== e) $display("FAIL cw_in01: got %h want %h", dout, e); else n_pass++;
        in_end();
    endtask

    task automatic test_error();
        int k;
        status_n = 1'b0; conf_done = 1'b0; init_done = 1'b0;
        out_port(2'b10, 8'h00);
        exp_q.push_back(8'h00);
        in_begin(2'b10);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        n_chk++; if (dout !== e) $display("FAIL er_cfg_low: got %h want %h", dout, e); else n_pass++;
        n_chk++; if (bus_en !== 1'b1) $display("FAIL er_bus_back: got %b want 1", bus_en); else n_pass++;
        in_end();
        out_port(2'b10, 8'h01);
        in_begin(2'b10);
        status_n = 1'b1;
        k = 0; while (dout[5:3] !== 3'd2 && k < 30) begin @(negedge clk); k++; end
        status_n = 1'b0;
        exp_q.push_back(8'h68);
        k = 0; while (dout[5:3] === 3'd2 && k < 20) begin @(negedge clk); k++; end
        e = exp_q.pop_front();
        n_chk++; if (dout !== e) $display("FAIL er_status: got %h want %h", dout, e); else n_pass++;
        n_chk++; if (bus_en !== 1'b1) $display("FAIL er_bus_en: got %b want 1", bus_en); else n_pass++;
        in_end();
        out_port(2'b10, 8'h00);
        exp_q.push_back(8'h00);
        in_begin(2'b10);
        repeat (2) @(negedge clk);
        e = exp_q.pop_front();
        n_chk++; if (dout !== e) $display("FAIL er_clear: got %h want %h", dout, e); else n_pass++;
        in_end();
    endtask

    task automatic test_timeout();
        int k, n;
        status_n = 1'b0;
        a7 = 1'b1; a6 = 1'b0; din = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 iorq_n = 1'b1; wr_n = 1'b1;
        k = 0; while (dout[5:3] !== 3'd1 && k < 20) begin @(negedge clk); k++; end
        n = 0; while (dout[5:3] === 3'd1 && n < 40) begin @(negedge clk); n++; end
        n_chk++; if (dout[6:3] !== 4'b1101) $display("FAIL to_error: got %b want 1101", dout[6:3]); else n_pass++;
        n_chk++; if (n < 15 || n > 16) $display("FAIL to_len: got %0d want 15..16", n); else n_pass++;
        n_chk++; if (bus_en !== 1'b1) $display("FAIL to_bus_en: got %b want 1", bus_en); else n_pass++;
        out_port(2'b10, 8'h00);
    endtask

    task automatic test_cold_mid();
        int k;
        status_n = 1'b0; conf_done = 1'b0; init_done = 1'b0;
        out_port(2'b01, 8'h83);
        out_port(2'b10, 8'h01);
        status_n = 1'b1; conf_done = 1'b1;
        k = 0; while (dout[5:3] !== 3'd3 && k < 30) begin @(negedge clk); k++; end
        n_chk++; if (dout[5:3] !== 3'd3) $display("FAIL cm_reach: got %0d want 3", dout[5:3]); else n_pass++;
        a15 = 1'b1; a14 = 1'b1; mreq_n = 1'b0; rd_n = 1'b0;
        @(posedge clk); #1 coldres_n = 1'b0;
        @(posedge clk); #1 coldres_n = 1'b1;
        @(negedge clk);
        n_chk++; if (config_n !== 1'b0) $display("FAIL cm_config_n: got %b want 0", config_n); else n_pass++;
        n_chk++; if (mema !== 4'b0001 || romcs_n !== 1'b0)
            $display("FAIL cm_page0: got mema%b rom%b want 0001 rom0", mema, romcs_n); else n_pass++;
        exp_q.push_back(8'd0);
        k = 0;
        while (warmres_n === 1'b0 && k < 40) begin k++; @(negedge clk); end
        n_chk++; if (k != 16) $display("FAIL cm_warm_len: got %0d want 16", k); else n_pass++;
        e = exp_q.pop_front();
        n_chk++; if (dout[5:3] !== e[2:0]) $display("FAIL cm_state: got %0d want %0d", dout[5:3], e[2:0]); else n_pass++;
        mreq_n = 1'b1; rd_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        repeat (4) @(posedge clk);
        test_paging();
        test_config_walk();
        test_error();
        test_timeout();
        test_cold_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
